// File: rtl/snake_step_engine.sv
// rtl/snake_step_engine.sv - snake step engine: tick sync, move, grow, serial self-collision scan
// Option: SNAKE_WALL_WRAP_EN makes the grid edges wrap instead of ending the game.
module snake_step_engine #(
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int MAX_LEN = 16,
  parameter int CW      = 5,
  localparam int IW = $clog2(MAX_LEN),
  localparam int LW = IW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          newClock,
  input  logic [3:0]    dirButtons,
  input  logic          restart,
  input  logic [CW-1:0] foodX,
  input  logic [CW-1:0] foodY,
  input  logic          foodValid,
  input  logic [IW-1:0] rdIndex,
  output logic [CW-1:0] rdX,
  output logic [CW-1:0] rdY,
  output logic          rdValid,
  output logic [CW-1:0] headX,
  output logic [CW-1:0] headY,
  output logic [LW-1:0] length,
  output logic          ateFood,
  output logic          stepDone,
  output logic          gameOver
);
  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, DONE, OVER} state_t;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

  state_t        state, state_n;
  dir_t          dir;
  logic [CW-1:0] bx [MAX_LEN];
  logic [CW-1:0] by [MAX_LEN];
  logic [LW-1:0] len;
  logic [IW-1:0] idx;
  logic          sync1, sync2, sync_prev, tick;
  logic [CW-1:0] nx, ny;
  logic          wall, hit_wall, eat, self_hit, last_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= newClock;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign tick = sync2 & ~sync_prev;

  // Edge tests happen before the arithmetic so no coordinate ever underflows.
  always_comb begin
    nx   = bx[0];
    ny   = by[0];
    wall = 1'b0;
    case (dir)
      UP:    if (by[0] == '0) begin wall = 1'b1; ny = CW'(GRID_H - 1); end
             else ny = by[0] - 1'b1;
      DOWN:  if (by[0] == CW'(GRID_H - 1)) begin wall = 1'b1; ny = '0; end
             else ny = by[0] + 1'b1;
      LEFT:  if (bx[0] == '0) begin wall = 1'b1; nx = CW'(GRID_W - 1); end
             else nx = bx[0] - 1'b1;
      default: if (bx[0] == CW'(GRID_W - 1)) begin wall = 1'b1; nx = '0; end
               else nx = bx[0] + 1'b1;
    endcase
  end

`ifdef SNAKE_WALL_WRAP_EN
  assign hit_wall = 1'b0;
`else
  assign hit_wall = wall;
`endif

  assign eat      = foodValid && (nx == foodX) && (ny == foodY);
  assign self_hit = (bx[idx] == bx[0]) && (by[idx] == by[0]);
  assign last_idx = (LW'(idx) == len - 1'b1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (tick) state_n = SHIFT;
      SHIFT:   state_n = hit_wall ? OVER : CHECK;
      CHECK:   if (self_hit) state_n = OVER;
               else if (last_idx) state_n = DONE;
      DONE:    state_n = IDLE;
      OVER:    state_n = OVER;
      default: state_n = IDLE;
    endcase
    if (restart) state_n = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        bx[i] <= (i < 3) ? CW'(GRID_W / 2 - i) : '0;
        by[i] <= (i < 3) ? CW'(GRID_H / 2) : '0;
      end
      len     <= LW'(3);
      dir     <= RIGHT;
      idx     <= '0;
      ateFood <= 1'b0;
      rdX     <= '0;
      rdY     <= '0;
      rdValid <= 1'b0;
    end else if (restart) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        bx[i] <= (i < 3) ? CW'(GRID_W / 2 - i) : '0;
        by[i] <= (i < 3) ? CW'(GRID_H / 2) : '0;
      end
      len     <= LW'(3);
      dir     <= RIGHT;
      idx     <= '0;
      ateFood <= 1'b0;
      rdX     <= '0;
      rdY     <= '0;
      rdValid <= 1'b0;
    end else begin
      ateFood <= 1'b0;
      // A reversal request is dropped rather than falling through to a lower priority button.
      if (state == IDLE) begin
        if (dirButtons[3])      begin if (dir != DOWN)  dir <= UP;    end
        else if (dirButtons[2]) begin if (dir != UP)    dir <= DOWN;  end
        else if (dirButtons[1]) begin if (dir != RIGHT) dir <= LEFT;  end
        else if (dirButtons[0]) begin if (dir != LEFT)  dir <= RIGHT; end
      end
      if (state == SHIFT && !hit_wall) begin
        for (int i = 1; i < MAX_LEN; i++) begin
          bx[i] <= bx[i-1];
          by[i] <= by[i-1];
        end
        bx[0] <= nx;
        by[0] <= ny;
        if (eat) begin
          ateFood <= 1'b1;
          if (len < LW'(MAX_LEN)) len <= len + 1'b1;
        end
        idx <= IW'(1);
      end
      if (state == CHECK) idx <= idx + 1'b1;
      rdValid <= (LW'(rdIndex) < len);
      rdX     <= (LW'(rdIndex) < len) ? bx[rdIndex] : '0;
      rdY     <= (LW'(rdIndex) < len) ? by[rdIndex] : '0;
    end
  end

  assign headX    = bx[0];
  assign headY    = by[0];
  assign length   = len;
  assign stepDone = (state == DONE);
  assign gameOver = (state == OVER);
endmodule

// File: tb/tb_snake_step_engine.sv
// tb/tb_snake_step_engine.sv - scoreboard bench for snake_step_engine against a reference snake model
`timescale 1ns/1ps
module tb_snake_step_engine;
  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          newClock = 1'b0;
  logic [3:0]    dirButtons = 4'b0;
  logic          restart = 1'b0;
  logic [CW-1:0] foodX = '0;
  logic [CW-1:0] foodY = '0;
  logic          foodValid = 1'b0;
  logic [3:0]    rdIndex = 4'd0;
  logic [CW-1:0] rdX, rdY, headX, headY;
  logic          rdValid, ateFood, stepDone, gameOver;
  logic [4:0]    length;

  always #5 clock = ~clock;

  snake_step_engine dut (
    .clock(clock), .reset(reset), .newClock(newClock), .dirButtons(dirButtons),
    .restart(restart), .foodX(foodX), .foodY(foodY), .foodValid(foodValid),
    .rdIndex(rdIndex), .rdX(rdX), .rdY(rdY), .rdValid(rdValid),
    .headX(headX), .headY(headY), .length(length), .ateFood(ateFood),
    .stepDone(stepDone), .gameOver(gameOver)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int ate_cnt  = 0;

  always @(negedge clock) begin
    if (stepDone) done_cnt++;
    if (ateFood)  ate_cnt++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model: directions 0 up, 1 down, 2 left, 3 right
  int mx[16];
  int my[16];
  int mlen, mdir;
  bit mover;

  typedef struct {int hx; int hy; int len; int over; int ate;} exp_t;
  exp_t sb[$];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mx[i] = (i < 3) ? 16 - i : 0;
      my[i] = (i < 3) ? 12 : 0;
    end
    mlen = 3; mdir = 3; mover = 0;
  endtask

  task automatic model_buttons(input logic [3:0] b);
    int req;
    req = -1;
    if (b[3]) req = 0; else if (b[2]) req = 1; else if (b[1]) req = 2; else if (b[0]) req = 3;
    if (!mover && req >= 0 && req != (mdir ^ 1)) mdir = req;
  endtask

  task automatic model_step(input bit fv, input int fx, input int fy, output exp_t e);
    int nx, ny;
    bit wall;
    e.ate = 0;
    if (!mover) begin
      nx = mx[0]; ny = my[0]; wall = 0;
      case (mdir)
        0: if (ny == 0)  begin wall = 1; ny = 23; end else ny = ny - 1;
        1: if (ny == 23) begin wall = 1; ny = 0;  end else ny = ny + 1;
        2: if (nx == 0)  begin wall = 1; nx = 31; end else nx = nx - 1;
        default: if (nx == 31) begin wall = 1; nx = 0; end else nx = nx + 1;
      endcase
`ifdef SNAKE_WALL_WRAP_EN
      wall = 0;
`endif
      if (wall) mover = 1;
      else begin
        for (int i = 15; i > 0; i--) begin mx[i] = mx[i-1]; my[i] = my[i-1]; end
        mx[0] = nx; my[0] = ny;
        if (fv && nx == fx && ny == fy) begin
          e.ate = 1;
          if (mlen < 16) mlen++;
        end
        for (int k = 1; k < mlen; k++)
          if (mx[k] == nx && my[k] == ny) mover = 1;
      end
    end
    e.hx = mx[0]; e.hy = my[0]; e.len = mlen; e.over = mover;
  endtask

  task automatic do_tick(input logic [3:0] btn, input bit fv, input int fx, input int fy,
                         input bit second_edge, output int lat);
    exp_t e, got;
    int d0, a0, cyc;
    bit was_over, seen;
    @(negedge clock);
    dirButtons = btn; foodValid = fv; foodX = CW'(fx); foodY = CW'(fy);
    model_buttons(btn);
    repeat (2) @(negedge clock);
    was_over = mover;
    model_step(fv, fx, fy, e);
    sb.push_back(e);
    d0 = done_cnt; a0 = ate_cnt;
    newClock = 1'b1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (second_edge && cyc == 2) newClock = 1'b0;
      if (second_edge && cyc == 4) newClock = 1'b1;
      if (!was_over && (stepDone || gameOver)) seen = 1;
    end
    lat = cyc;
    if (!was_over) check_eq("step_event_seen", int'(seen), 1);
    repeat (24) @(negedge clock);
    newClock = 1'b0;
    dirButtons = 4'b0;
    got = sb.pop_front();
    check_eq("head_x", int'(headX), got.hx);
    check_eq("head_y", int'(headY), got.hy);
    check_eq("length", int'(length), got.len);
    check_eq("game_over", int'(gameOver), got.over);
    check_eq("ate_pulses", ate_cnt - a0, got.ate);
    check_eq("step_done_pulses", done_cnt - d0, (got.over != 0) ? 0 : 1);
  endtask

  task automatic rd_check(input int idx);
    @(negedge clock);
    rdIndex = 4'(idx);
    @(negedge clock);
    check_eq("rd_valid", int'(rdValid), (idx < mlen) ? 1 : 0);
    check_eq("rd_x", int'(rdX), (idx < mlen) ? mx[idx] : 0);
    check_eq("rd_y", int'(rdY), (idx < mlen) ? my[idx] : 0);
  endtask

  task automatic do_restart();
    @(negedge clock);
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    model_reset();
    check_eq("restart_head_x", int'(headX), 16);
    check_eq("restart_head_y", int'(headY), 12);
    check_eq("restart_length", int'(length), 3);
    check_eq("restart_game_over", int'(gameOver), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    model_reset();
    repeat (3) @(negedge clock);
    check_eq("reset_head_x", int'(headX), 16);
    check_eq("reset_head_y", int'(headY), 12);
    check_eq("reset_length", int'(length), 3);
    check_eq("reset_game_over", int'(gameOver), 0);
    check_eq("reset_step_done", int'(stepDone), 0);
    check_eq("reset_ate_food", int'(ateFood), 0);
    check_eq("reset_rd_valid", int'(rdValid), 0);
    check_eq("reset_rd_x", int'(rdX), 0);
    reset = 1'b0;

    do_tick(4'b0000, 0, 0, 0, 0, lat);
    check_eq("step_latency_in_6_to_7", int'(lat >= 6 && lat <= 7), 1);
    rd_check(2);

    do_restart();
    do_tick(4'b0010, 0, 0, 0, 0, lat);
    do_restart();
    do_tick(4'b1000, 0, 0, 0, 0, lat);

    do_restart();
    do_tick(4'b0000, 1, 17, 12, 0, lat);
    rd_check(3);
    rd_check(4);

    do_tick(4'b0000, 1, 18, 12, 0, lat);
    do_tick(4'b1000, 0, 0, 0, 0, lat);
    do_tick(4'b0010, 0, 0, 0, 0, lat);
    do_tick(4'b0100, 0, 0, 0, 0, lat);
    do_tick(4'b1000, 0, 0, 0, 0, lat);
    do_restart();
    rd_check(1);

    for (int t = 0; t < 16; t++) do_tick(4'b0001, 0, 0, 0, 0, lat);

    do_restart();
    do_tick(4'b0000, 0, 0, 0, 1, lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
